spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
SPI master (initiator) that runs a full-duplex LEN_DATA-bit frame on request from a parallel host interface. It generates SS, SCLK and MOSI from the system clock and captures MISO into a parallel result. It is the controller end of the codebase's SPI slave protocol:
- SCLK idles low.
- The slave samples MOSI and updates MISO on the SCLK falling edge.
- Data is sent LSB first.

Parameters:
LEN_DATA, 8, frame length in bits (>=2)
CLK_DIV, 4, system clocks per SCLK half-period (>=1)
SS_GAP, 2, minimum CLK cycles with SS high between frames (>=1)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge
start  input  1  frame request, sampled only when busy=0
tx_data  input  LEN_DATA  word to send, captured when start is accepted
busy  output  1  high from the cycle after start is accepted until the GAP phase ends
done  output  1  one-cycle pulse: frame complete, rx_data valid
rx_data  output  LEN_DATA  last received word, held until the next done
SCLK  output  1  SPI clock, registered
MOSI  output  1  master-out data, registered
MISO  input  1  slave-out data
SS  output  1  active-low slave select, registered

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - SS=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=0.
  - FSM goes to IDLE, divider counter and bit counter are cleared.
  - Reset mid-frame aborts immediately: SS goes high on that edge and no done is produced.
- FSM states: IDLE, LEAD, HIGH, LOW, TRAIL, GAP.
- Each of LEAD, HIGH, LOW and TRAIL lasts exactly CLK_DIV cycles, timed by the divider counter.
- IDLE:
  - start=1 at edge N latches tx_data into the shift register and moves to LEAD.
  - At edge N: SS=0, MOSI=tx_data[0], SCLK=0, busy=1.
- LEAD -> HIGH: SCLK=1.
- HIGH -> LOW: SCLK=0. This is the falling edge; the slave takes MOSI bit i here.
- End of LOW, on the same edge:
  - Sample MISO into rx shift bit i.
  - If i<LEN_DATA-1: drive MOSI=tx bit i+1 and go to HIGH.
  - Else: go to TRAIL, with SCLK held at 0.
- TRAIL -> GAP:
  - SS=1, MOSI=0.
  - rx_data is loaded from the rx shift register and done=1 for exactly one cycle.
- GAP: SS stays high for SS_GAP cycles, busy stays 1, then the FSM goes to IDLE with busy=0.
- Frame timing:
  - done is high in the cycle after edge N+CLK_DIV*(2*LEN_DATA+2).
  - Example: CLK_DIV=4, LEN_DATA=8 gives 72 cycles.
  - Exactly LEN_DATA SCLK rising and LEN_DATA falling edges per frame.
- Signal stability:
  - MOSI never changes while SCLK=1.
  - SS changes only while SCLK=0.
- Illegal and simultaneous conditions:
  - start while busy=1 is ignored, with no queuing.
  - start held high continuously gives back-to-back frames separated by exactly SS_GAP+1 cycles of SS high.
  - tx_data changes after acceptance have no effect on the frame in progress.
- Counter widths: divider $clog2(CLK_DIV)+1, bit counter $clog2(LEN_DATA)+1. Both are cleared at frame start and never wrap mid-frame.

Optional Feature:
SPI_MASTER_MSB_FIRST_EN:
- Defined: tx is sent tx_data[LEN_DATA-1] first, and the first sampled MISO bit goes to rx_data[LEN_DATA-1].
- Undefined (default): LSB first, matching the existing slave.
- Timing is identical in both cases.

Test Plan:
- Loopback: MISO tied to MOSI, CLK_DIV=4, tx_data=0xA5, pulse start -> MOSI sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; done exactly 72 cycles after the accepting edge; 8 SCLK pulses, each 4 cycles high and 4 low.
- Against the codebase slave model preloaded with 0x3F: send tx 0xC3 -> rx_data=0x3F; slave register holds 0xC3 after the frame; SS low for the whole frame.
- start asserted again at cycle 20 of an active frame -> ignored; exactly one done; busy stays 1 until the GAP phase ends.
- start held at 1 for two frames (0x01, then 0x80 presented after the first done) -> two done pulses 72+SS_GAP+1 cycles apart; SS high for exactly SS_GAP+1=3 cycles between frames.
- RST_N driven low at cycle 30 of a frame -> next edge: SS=1, SCLK=0, MOSI=0, busy=0, rx_data=0; no done; a new start then runs a clean 72-cycle frame.
- Macro defined, loopback, tx 0x01 -> MOSI first bit 0, last bit 1; rx_data=0x01.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: SPI master with idle-low SCLK and LSB-first frames; define SPI_MASTER_MSB_FIRST_EN for MSB-first frames
module spi_master #(
  parameter int LEN_DATA = 8,
  parameter int CLK_DIV  = 4,
  parameter int SS_GAP   = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [LEN_DATA-1:0] tx_data,
  output logic                busy,
  output logic                done,
  output logic [LEN_DATA-1:0] rx_data,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO,
  output logic                SS
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(LEN_DATA) + 1;
  localparam int GW = $clog2(SS_GAP) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LEN_DATA - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(SS_GAP - 1);
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [BW-1:0] cnt;
  logic [GW-1:0] gap;
  logic [LEN_DATA-1:0] tx_sr, rx_sr, tx_load, tx_shift, rx_shift;
  logic div_end, tx_first, tx_next;
  assign div_end = div == DIV_LAST;
`ifdef SPI_MASTER_MSB_FIRST_EN
  assign tx_first = tx_data[LEN_DATA-1];
  assign tx_load  = tx_data << 1;
  assign tx_next  = tx_sr[LEN_DATA-1];
  assign tx_shift = tx_sr << 1;
  assign rx_shift = {rx_sr[LEN_DATA-2:0], MISO};
`else
  assign tx_first = tx_data[0];
  assign tx_load  = tx_data >> 1;
  assign tx_next  = tx_sr[0];
  assign tx_shift = tx_sr >> 1;
  assign rx_shift = {MISO, rx_sr[LEN_DATA-1:1]};
`endif
  // frame sequencer: every phase output is registered so SS/SCLK/MOSI are glitch-free
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      div     <= '0;
      cnt     <= '0;
      gap     <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      SS      <= 1'b1;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state inside {LEAD, HIGH, LOW, TRAIL}) div <= div_end ? '0 : div + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= LEAD;
          tx_sr <= tx_load;
          rx_sr <= '0;
          MOSI  <= tx_first;
          SS    <= 1'b0;
          SCLK  <= 1'b0;
          busy  <= 1'b1;
          cnt   <= '0;
          div   <= '0;
        end
        LEAD: if (div_end) begin
          state <= HIGH;
          SCLK  <= 1'b1;
        end
        HIGH: if (div_end) begin
          state <= LOW;
          SCLK  <= 1'b0;
        end
        LOW: if (div_end) begin
          rx_sr <= rx_shift;
          if (cnt == BIT_LAST) state <= TRAIL;
          else begin
            state <= HIGH;
            SCLK  <= 1'b1;
            MOSI  <= tx_next;
            tx_sr <= tx_shift;
            cnt   <= cnt + 1'b1;
          end
        end
        TRAIL: if (div_end) begin
          state   <= GAP;
          SS      <= 1'b1;
          MOSI    <= 1'b0;
          rx_data <= rx_sr;
          done    <= 1'b1;
          gap     <= '0;
        end
        GAP: if (gap == GAP_LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else gap <= gap + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master (default 8-bit, CLK_DIV=4, SS_GAP=2) with loopback and a falling-edge slave model
module tb_spi_master;
  logic CLK = 1'b0, RST_N = 1'b0, start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic busy, done, SCLK, MOSI, SS, MISO;
  logic [7:0] rx_data;
  logic loop = 1'b1, miso_slv = 1'b0;
  logic [7:0] slv = 8'h00;
  int tests = 0, fails = 0;

  spi_master dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
    .rx_data(rx_data), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS(SS)
  );

  always #5 CLK = ~CLK;
  assign MISO = loop ? MOSI : miso_slv;

  // slave: on each SCLK fall it takes MOSI into its register and presents its next bit, LSB first
  always @(negedge SCLK) if (!SS) begin
    miso_slv <= slv[0];
    slv <= {MOSI, slv[7:1]};
  end

  function automatic logic [7:0] rev(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] exp_seq(input logic [7:0] v);
`ifdef SPI_MASTER_MSB_FIRST_EN
    return rev(v);
`else
    return v;
`endif
  endfunction

  task automatic run_frame(input logic [7:0] tx, input int poke_at, input int abort_at,
      output int done_cyc, output int dones, output logic [7:0] mosi_seq, output int rises,
      output int errs, output int ss_high, output int busy_low, output logic [11:0] snap);
    int last_rise;
    logic prev_sclk, prev_mosi;
    done_cyc = -1; dones = 0; mosi_seq = '0; rises = 0; errs = 0; ss_high = 0;
    busy_low = -1; snap = '1; last_rise = -1; prev_sclk = 1'b0; prev_mosi = 1'b0;
    @(negedge CLK); start = 1'b1; tx_data = tx;
    @(negedge CLK); start = 1'b0; tx_data = ~tx;
    for (int k = 0; k < 100; k++) begin
      if (k == poke_at) begin start = 1'b1; tx_data = 8'hFF; end
      if (k == poke_at + 1) start = 1'b0;
      if (k == abort_at) RST_N = 1'b0;
      if (k == abort_at + 1) begin snap = {SS, SCLK, MOSI, busy, rx_data}; RST_N = 1'b1; end
      if (done === 1'b1) begin dones++; if (done_cyc < 0) done_cyc = k; end
      if (k < 72 && SS !== 1'b0) ss_high++;
      if (busy === 1'b0 && busy_low < 0) busy_low = k;
      if (SCLK && !prev_sclk) begin
        if (rises < 8) mosi_seq[rises] = MOSI;
        if (rises > 0 ? k - last_rise != 8 : k != 4) errs++;
        last_rise = k;
        rises++;
      end
      if (!SCLK && prev_sclk && k - last_rise != 4) errs++;
      if (SCLK && prev_sclk && MOSI !== prev_mosi) errs++;
      prev_sclk = SCLK; prev_mosi = MOSI;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    tests++; if ({SS, SCLK, MOSI} !== 3'b100) begin fails++; $display("FAIL reset_pins: got %b want 100", {SS, SCLK, MOSI}); end
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_status: got %b want 00", {busy, done}); end
    tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx: got %h want 00", rx_data); end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_loopback(input logic [7:0] tx);
    int dc, dn, ri, er, sh, bl;
    logic [7:0] ms;
    logic [11:0] sn;
    loop = 1'b1;
    run_frame(tx, -1, -1, dc, dn, ms, ri, er, sh, bl, sn);
    tests++; if (ms !== exp_seq(tx)) begin fails++; $display("FAIL lb_mosi_%h: got %b want %b (bit0 first)", tx, ms, exp_seq(tx)); end
    tests++; if (rx_data !== tx) begin fails++; $display("FAIL lb_rx_%h: got %h want %h", tx, rx_data, tx); end
    tests++; if (dc != 72) begin fails++; $display("FAIL lb_done_cycle_%h: got %0d want 72", tx, dc); end
    tests++; if (dn != 1) begin fails++; $display("FAIL lb_done_count_%h: got %0d want 1", tx, dn); end
    tests++; if (ri != 8) begin fails++; $display("FAIL lb_sclk_rises_%h: got %0d want 8", tx, ri); end
    tests++; if (er != 0) begin fails++; $display("FAIL lb_sclk_timing_%h: got %0d errors want 0", tx, er); end
    tests++; if (sh != 0) begin fails++; $display("FAIL lb_ss_low_%h: got %0d high cycles want 0", tx, sh); end
    tests++; if (bl != 74) begin fails++; $display("FAIL lb_busy_end_%h: got %0d want 74", tx, bl); end
  endtask

  task automatic test_slave();
    int dc, dn, ri, er, sh, bl;
    logic [7:0] ms;
    logic [11:0] sn;
    loop = 1'b0;
    slv = 8'h3F;
    run_frame(8'hC3, -1, -1, dc, dn, ms, ri, er, sh, bl, sn);
    tests++; if (rx_data !== 8'h3F) begin fails++; $display("FAIL slave_rx: got %h want 3f", rx_data); end
    tests++; if (slv !== 8'hC3) begin fails++; $display("FAIL slave_reg: got %h want c3", slv); end
    tests++; if (sh != 0) begin fails++; $display("FAIL slave_ss_low: got %0d high cycles want 0", sh); end
    tests++; if (dc != 72) begin fails++; $display("FAIL slave_done_cycle: got %0d want 72", dc); end
    loop = 1'b1;
  endtask

  task automatic test_ignore_start();
    int dc, dn, ri, er, sh, bl;
    logic [7:0] ms;
    logic [11:0] sn;
    loop = 1'b1;
    run_frame(8'h3C, 20, -1, dc, dn, ms, ri, er, sh, bl, sn);
    tests++; if (dn != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL ignore_rx: got %h want 3c", rx_data); end
    tests++; if (bl != 74) begin fails++; $display("FAIL ignore_busy_end: got %0d want 74", bl); end
    tests++; if (dc != 72) begin fails++; $display("FAIL ignore_done_cycle: got %0d want 72", dc); end
  endtask

  task automatic test_reset_abort();
    int dc, dn, ri, er, sh, bl;
    logic [7:0] ms;
    logic [11:0] sn;
    loop = 1'b1;
    run_frame(8'h96, -1, 30, dc, dn, ms, ri, er, sh, bl, sn);
    tests++; if (sn !== 12'h800) begin fails++; $display("FAIL abort_state: got %h want 800 (SS,SCLK,MOSI,busy,rx)", sn); end
    tests++; if (dn != 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    run_frame(8'h5A, -1, -1, dc, dn, ms, ri, er, sh, bl, sn);
    tests++; if (dc != 72 || dn != 1) begin fails++; $display("FAIL abort_restart_done: got cycle %0d count %0d want 72/1", dc, dn); end
    tests++; if (rx_data !== 8'h5A) begin fails++; $display("FAIL abort_restart_rx: got %h want 5a", rx_data); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, rise_k, gap_len;
    logic prev_ss;
    logic [7:0] rx1, rx2;
    d1 = -1; d2 = -1; rise_k = -1; gap_len = -1; prev_ss = 1'b1; rx1 = 8'h00; rx2 = 8'h00;
    loop = 1'b1;
    @(negedge CLK); start = 1'b1; tx_data = 8'h01;
    for (int k = 0; k < 300; k++) begin
      if (done === 1'b1) begin
        if (d1 < 0) begin d1 = k; rx1 = rx_data; tx_data = 8'h80; end
        else if (d2 < 0) begin d2 = k; rx2 = rx_data; start = 1'b0; end
      end
      if (SS && !prev_ss) rise_k = k;
      if (!SS && prev_ss && rise_k >= 0 && gap_len < 0) gap_len = k - rise_k;
      prev_ss = SS;
      @(negedge CLK);
    end
    start = 1'b0;
    tests++; if (d1 < 0 || d2 < 0 || d2 - d1 != 75) begin fails++; $display("FAIL b2b_done_spacing: got %0d,%0d want spacing 75", d1, d2); end
    tests++; if (gap_len != 3) begin fails++; $display("FAIL b2b_ss_gap: got %0d want 3", gap_len); end
    tests++; if (rx1 !== 8'h01) begin fails++; $display("FAIL b2b_rx1: got %h want 01", rx1); end
    tests++; if (rx2 !== 8'h80) begin fails++; $display("FAIL b2b_rx2: got %h want 80", rx2); end
  endtask

  initial begin
    test_reset();
    test_loopback(8'hA5);
    test_loopback(8'h01);
`ifndef SPI_MASTER_MSB_FIRST_EN
    test_slave();
`endif
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
